ship_game_controller: RTL

Sequences game play for the VGA spaceship game: conditions the four push-buttons, tracks the ship heading (16 orientations, 22.5 deg steps) and the selected weapon, and keeps the score. It also runs the TITLE/PLAY/OVER game state machine. Its outputs drive sprite selection, score digit conversion and the pixel colour logic in the top level. Heading changes are frame-synchronous so a sprite never changes mid-frame.

---
 rtl/ship_game_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ship_game_controller.sv
// Game-play sequencer for the spaceship game: button conditioning, TITLE/PLAY/OVER FSM, heading, weapon and score.
// Optional macro AUTO_REPEAT_EN adds frame-based auto-repeat for held rotate buttons.
module ship_game_controller #(
    parameter int DEBOUNCE_CYCLES = 252000,
    parameter int NUM_WEAPONS     = 3,
    parameter int SCORE_MAX       = 99999
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES   = 8
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        frame_tick,
    input  logic        Rotate_CW,
    input  logic        Rotate_CCW,
    input  logic        Weapon_switch,
    input  logic        Interaction,
    input  logic        ship_hit,
    input  logic        enemy_kill,
    input  logic [7:0]  kill_points,
    output logic [1:0]  game_state,
    output logic [3:0]  heading,
    output logic [1:0]  weapon,
    output logic [17:0] score
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ZERO   = {DBW{1'b0}};
    localparam logic [1:0]     WPN_LAST  = 2'(NUM_WEAPONS - 1);
    localparam logic [17:0]    SCORE_SAT = 18'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_TITLE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    // Button bit order: 0=CW, 1=CCW, 2=weapon, 3=interaction
    logic [3:0]     w_raw;
    logic [3:0]     r_sync1, r_sync2, r_deb, r_deb_d;
    logic [DBW-1:0] r_cnt [4];
    logic [3:0]     w_press;

    state_t         r_state, w_state_nxt;
    logic           w_in_play, w_play_nxt;
    logic           r_pend_cw, r_pend_ccw, w_pend_cw_nxt, w_pend_ccw_nxt;
    logic           w_cw_evt, w_ccw_evt, w_eff_cw, w_eff_ccw;
    logic [1:0]     w_rep;
    logic [3:0]     r_heading, w_heading_nxt;
    logic [1:0]     r_weapon, w_weapon_nxt;
    logic [17:0]    r_score, w_score_nxt, w_sum;

    assign w_raw   = {Interaction, Weapon_switch, Rotate_CCW, Rotate_CW};
    assign w_press = r_deb & ~r_deb_d;

    // Synchronise raw buttons and accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_deb   <= 4'b0000;
            r_deb_d <= 4'b0000;
            for (int i = 0; i < 4; i++) r_cnt[i] <= DB_ZERO;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= DB_ZERO;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= DB_ZERO;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // Game state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_TITLE;
        else       r_state <= w_state_nxt;
    end

    // Game state transitions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_TITLE: if (w_press[3]) w_state_nxt = ST_PLAY; else w_state_nxt = ST_TITLE;
            ST_PLAY:  if (ship_hit)   w_state_nxt = ST_OVER; else w_state_nxt = ST_PLAY;
            ST_OVER:  if (w_press[3]) w_state_nxt = ST_PLAY; else w_state_nxt = ST_OVER;
            default:  w_state_nxt = ST_TITLE;
        endcase
    end

    assign w_in_play  = (r_state == ST_PLAY);
    assign w_play_nxt = (w_state_nxt == ST_PLAY);
    assign w_cw_evt   = w_press[0] & ~w_press[1];
    assign w_ccw_evt  = w_press[1] & ~w_press[0];

`ifdef AUTO_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_FRAMES - 1);
    localparam logic [RPW-1:0] RP_ZERO = {RPW{1'b0}};
    logic [RPW-1:0] r_rep_cnt [2];

    // Repeat fires on the tick that completes another REPEAT_FRAMES-frame period of a held rotate button
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_rep[i] = w_in_play & r_deb[i] & frame_tick & (r_rep_cnt[i] == RP_LAST);
        end
    end

    // Frame counters for held rotate buttons, cleared on release or outside PLAY
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 2; i++) r_rep_cnt[i] <= RP_ZERO;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_in_play || !r_deb[i])      r_rep_cnt[i] <= RP_ZERO;
                else if (frame_tick && w_rep[i])  r_rep_cnt[i] <= RP_ZERO;
                else if (frame_tick)              r_rep_cnt[i] <= r_rep_cnt[i] + RPW'(1);
                else                              r_rep_cnt[i] <= r_rep_cnt[i];
            end
        end
    end
`else
    assign w_rep = 2'b00;
`endif

    assign w_eff_cw  = r_pend_cw  | w_rep[0];
    assign w_eff_ccw = r_pend_ccw | w_rep[1];
    assign w_sum     = r_score + {10'b0000000000, kill_points};

    // Next heading, pending flags, weapon and score
    always_comb begin
        w_pend_cw_nxt  = r_pend_cw;
        w_pend_ccw_nxt = r_pend_ccw;
        w_heading_nxt  = r_heading;
        w_weapon_nxt   = r_weapon;
        w_score_nxt    = r_score;
        if (!w_play_nxt) begin
            w_pend_cw_nxt  = 1'b0;
            w_pend_ccw_nxt = 1'b0;
        end else if (!w_in_play) begin
            w_pend_cw_nxt  = 1'b0;
            w_pend_ccw_nxt = 1'b0;
            w_heading_nxt  = 4'd0;
        end else if (frame_tick) begin
            // The tick consumes current flags; a press in this same cycle arms the next tick
            if (w_eff_cw && !w_eff_ccw)      w_heading_nxt = r_heading + 4'd1;
            else if (w_eff_ccw && !w_eff_cw) w_heading_nxt = r_heading - 4'd1;
            else                             w_heading_nxt = r_heading;
            w_pend_cw_nxt  = w_cw_evt;
            w_pend_ccw_nxt = w_ccw_evt;
        end else begin
            w_pend_cw_nxt  = r_pend_cw  | w_cw_evt;
            w_pend_ccw_nxt = r_pend_ccw | w_ccw_evt;
        end

        if (w_play_nxt && !w_in_play) begin
            w_weapon_nxt = 2'd0;
            w_score_nxt  = 18'd0;
        end else if (w_in_play) begin
            if (w_press[2]) w_weapon_nxt = (r_weapon == WPN_LAST) ? 2'd0 : r_weapon + 2'd1;
            else            w_weapon_nxt = r_weapon;
            if (enemy_kill) w_score_nxt = (w_sum > SCORE_SAT) ? SCORE_SAT : w_sum;
            else            w_score_nxt = r_score;
        end else begin
            w_weapon_nxt = r_weapon;
            w_score_nxt  = r_score;
        end
    end

    // Play-state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pend_cw  <= 1'b0;
            r_pend_ccw <= 1'b0;
            r_heading  <= 4'd0;
            r_weapon   <= 2'd0;
            r_score    <= 18'd0;
        end else begin
            r_pend_cw  <= w_pend_cw_nxt;
            r_pend_ccw <= w_pend_ccw_nxt;
            r_heading  <= w_heading_nxt;
            r_weapon   <= w_weapon_nxt;
            r_score    <= w_score_nxt;
        end
    end

    assign game_state = r_state;
    assign heading    = r_heading;
    assign weapon     = r_weapon;
    assign score      = r_score;

endmodule
